// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline stage register with valid/ready handshake, flush and a
// saturating downstream-stall counter. Define IF_ID_SKID_EN to add a one-entry skid buffer.
module if_id_stage_reg #(
    parameter int unsigned         PC_W      = 32,
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [15:0]        out_stall_cnt
);

    localparam int unsigned  CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               accept;
    logic               consume;
    logic               valid_d;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] instr_d;
    logic [CNT_W-1:0]   cnt_d;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Stall counter: counts held-output cycles, frozen by flush, never wraps
    always_comb begin
        cnt_d = out_stall_cnt;
        if (!flush && out_valid && !out_ready && (out_stall_cnt != CNT_MAX))
            cnt_d = out_stall_cnt + CNT_W'(1);
    end

`ifdef IF_ID_SKID_EN
    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               skid_valid_d;
    logic [PC_W-1:0]    skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_d;
    logic               in_ready_q;

    // Ready comes from a flop; rst gating only forces it low during reset
    assign in_ready = in_ready_q && !rst;

    always_comb begin
        valid_d      = out_valid;
        pc_d         = out_pc;
        instr_d      = out_instr;
        skid_valid_d = skid_valid;
        skid_pc_d    = skid_pc;
        skid_instr_d = skid_instr;
        if (flush) begin
            valid_d      = 1'b0;
            pc_d         = '0;
            instr_d      = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                valid_d      = 1'b1;
                pc_d         = skid_pc;
                instr_d      = skid_instr;
                skid_valid_d = accept;
                if (accept) begin
                    skid_pc_d    = in_pc;
                    skid_instr_d = in_instr;
                end
            end else if (accept) begin
                valid_d = 1'b1;
                pc_d    = in_pc;
                instr_d = in_instr;
            end else if (consume) begin
                valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
            in_ready_q <= 1'b1;
        end else begin
            skid_valid <= skid_valid_d;
            skid_pc    <= skid_pc_d;
            skid_instr <= skid_instr_d;
            in_ready_q <= !skid_valid_d;
        end
    end
`else
    // Output slot is free when empty or draining this cycle
    assign in_ready = (!out_valid || out_ready) && !rst;

    always_comb begin
        valid_d = out_valid;
        pc_d    = out_pc;
        instr_d = out_instr;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            instr_d = NOP_INSTR;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instr;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_instr     <= NOP_INSTR;
            out_stall_cnt <= '0;
        end else begin
            out_valid     <= valid_d;
            out_pc        <= pc_d;
            out_instr     <= instr_d;
            out_stall_cnt <= cnt_d;
        end
    end

endmodule
